// File: rtl/serial_deserializer8.sv
// Serial-to-parallel collector for a shift-register operand path: drives ShiftEn, samples SIn,
// pulses Done when the word is complete. Optional trailing even-parity bit via DESER_PARITY_EN.
module serial_deserializer8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Dir,
  input  logic             SIn,
  output logic             ShiftEn,
  output logic             Busy,
  output logic             Done,
`ifdef DESER_PARITY_EN
  output logic             ParityErr,
`endif
  output logic [WIDTH-1:0] Q
);

`ifdef DESER_PARITY_EN
  localparam int unsigned NBits = WIDTH + 1;
`else
  localparam int unsigned NBits = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NBits - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              store_bit;
  logic              accept;

`ifdef DESER_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  // The parity bit arrives last and is never shifted into the word.
  assign store_bit = (cnt_q != CntW'(WIDTH));
`else
  assign store_bit = 1'b1;
`endif

  assign accept = Start && (state_q != StShift);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    q_d     = q_q;
`ifdef DESER_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    if (Abort) begin
      state_d = StIdle;
    end else if (accept) begin
      state_d = StShift;
      dir_d   = Dir;
      cnt_d   = '0;
`ifdef DESER_PARITY_EN
      par_d   = 1'b0;
      perr_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StShift: begin
          cnt_d = cnt_q + 1'b1;
          if (store_bit) begin
            q_d = dir_q ? {q_q[WIDTH-2:0], SIn} : {SIn, q_q[WIDTH-1:1]};
          end
`ifdef DESER_PARITY_EN
          par_d = par_q ^ SIn;
`endif
          if (cnt_q == LastCnt) begin
            state_d = StDone;
`ifdef DESER_PARITY_EN
            perr_d  = par_q ^ SIn;
`endif
          end
        end
        StDone:  state_d = StIdle;
        StIdle:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign ParityErr = perr_q;
`endif

  assign ShiftEn = (state_q == StShift);
  assign Busy    = (state_q == StShift);
  assign Done    = (state_q == StDone);
  assign Q       = q_q;

endmodule

// File: tb/tb_serial_deserializer8.sv
// Randomized and directed bench for serial_deserializer8; expected words come from a bit-queue
// model of the source register. Build with DESER_PARITY_EN to cover the parity variant.
module tb_serial_deserializer8;
  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort_i, dir, sin;
  logic         shift_en, busy, done;
  logic [W-1:0] q;
`ifdef DESER_PARITY_EN
  logic         par_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] q_model;

  always #5 clk = ~clk;

  serial_deserializer8 #(.WIDTH(W)) dut (
    .CLK      (clk),
    .Reset    (rst),
    .Start    (start),
    .Abort    (abort_i),
    .Dir      (dir),
    .SIn      (sin),
    .ShiftEn  (shift_en),
    .Busy     (busy),
    .Done     (done),
`ifdef DESER_PARITY_EN
    .ParityErr(par_err),
`endif
    .Q        (q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // {Busy, ShiftEn, Done}
  function automatic logic [31:0] outs();
    return {29'd0, busy, shift_en, done};
  endfunction

  // Called at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
  task automatic xfer(input logic [W-1:0] w, input logic d, input logic pbit, input logic hold);
    logic bits[$];
    for (int i = 0; i < W; i++) bits.push_back(d ? w[W-1-i] : w[i]);
    if (N > W) bits.push_back(pbit);
    start = 1'b1;
    dir   = d;
    @(negedge clk);
    start = hold;
    dir   = ~d;
    for (int i = 0; i < N; i++) begin
      chk("shift_outs", outs(), 32'b110);
`ifdef DESER_PARITY_EN
      if (i == 0) chk("perr_cleared", 32'(par_err), 32'd0);
`endif
      sin = bits[i];
      @(negedge clk);
    end
    chk("done_outs", outs(), 32'b001);
    chk("done_q", 32'(q), 32'(w));
`ifdef DESER_PARITY_EN
    chk("parity_err", 32'(par_err), 32'(^{w, pbit}));
`endif
    q_model = w;
  endtask

  initial begin
    logic [W-1:0] w;
    logic         d;
    int           gap;

    rst = 1'b1; start = 1'b0; abort_i = 1'b0; dir = 1'b0; sin = 1'b0;
    #1;
    chk("reset_outs", outs(), 32'd0);
    chk("reset_q", 32'(q), 32'd0);
`ifdef DESER_PARITY_EN
    chk("reset_perr", 32'(par_err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(), 32'd0);

    xfer(8'hA5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_done_idle", outs(), 32'd0);
    chk("q_held", 32'(q), 32'h0A5);
    xfer(8'h3C, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Start held high: back-to-back words with no idle cycle.
    xfer(8'h01, 1'b0, 1'b1, 1'b1);
    xfer(8'h80, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    @(negedge clk);

    // Abort after four samples: no sample on the abort edge, partial Q kept.
    w = 8'h5A;
    start = 1'b1; dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin = w[i];
      @(negedge clk);
    end
    abort_i = 1'b1;
    sin = w[4];
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_outs", outs(), 32'd0);
    chk("abort_q", 32'(q), 32'((q_model >> 4) | ((w & 8'h0F) << 4)));
    for (int i = 0; i < N + 2; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    xfer(8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Abort coinciding with the last sample suppresses Done.
    start = 1'b1; dir = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      sin = 1'b1;
      @(negedge clk);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_last_outs", outs(), 32'd0);
    @(negedge clk);
    chk("abort_last_no_done", outs(), 32'd0);

    // Asynchronous reset between edges in mid-transfer.
    start = 1'b1; dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sin = 1'b1;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", outs(), 32'd0);
    chk("async_rst_q", 32'(q), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", outs(), 32'd0);
    @(negedge clk);
    chk("post_rst_still_idle", outs(), 32'd0);
    xfer(8'hC3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

`ifdef DESER_PARITY_EN
    xfer(8'hA5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    xfer(8'hA5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
`endif

    // Random words, directions, parity bits and idle gaps.
    for (int t = 0; t < 16; t++) begin
      w = W'($urandom);
      d = 1'($urandom);
      xfer(w, d, 1'($urandom), 1'b0);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap_idle", outs(), 32'd0);
        chk("gap_q_held", 32'(q), 32'(q_model));
      end
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
